// File: rtl/key_loader.sv
// ---------------------------------------------------------------------------
// key_loader
//   Receives a logic-locking key bit-serially (LSB first) over a valid/ready
//   stream, followed by one even-parity trailer bit. A load whose parity
//   checks commits the whole key in one step onto keyinput. A failed load
//   commits nothing. After a failed load, a zeroize or a reset, keyinput
//   reads all-zeros, which keeps the locked core in its corrupted mode.
//
// Ports
//   CK        in   clock, rising edge
//   RST       in   asynchronous active-high reset
//   start     in   begin / restart a key load
//   zeroize   in   synchronous clear of key and status (highest priority)
//   sdata     in   serial key bit or parity trailer bit
//   svalid    in   sdata valid this cycle
//   sready    out  block accepts sdata this cycle (LOAD or PARITY)
//   keyinput  out  committed key driving the key gates
//   key_valid out  keyinput holds a parity-checked key
//   key_err   out  last load failed its parity check
//   busy      out  load in progress (same as sready)
//
// States
//   state  | meaning
//   IDLE   | waiting for start; committed key (if any) stays applied
//   LOAD   | receiving key bits into shadow
//   PARITY | receiving the even-parity trailer bit
// ---------------------------------------------------------------------------
module key_loader #(
  parameter int KEY_WIDTH = 2
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 zeroize,
  input  logic                 sdata,
  input  logic                 svalid,
  output logic                 sready,
  output logic [KEY_WIDTH-1:0] keyinput,
  output logic                 key_valid,
  output logic                 key_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(KEY_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t               state_q;
  logic [KEY_WIDTH-1:0] shadow_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 par_q;
  logic                 key_valid_q;
  logic                 key_err_q;

  logic [KEY_WIDTH-1:0] shadow_d;
  logic                 par_d;
  logic                 last_bit_d;
  logic                 xfer_d;

  // shadow is cleared at load start, so OR-ing the bit into position
  // cnt_q is equivalent to writing shadow[cnt_q].
  assign shadow_d   = shadow_q | (KEY_WIDTH'(sdata) << cnt_q);
  assign par_d      = par_q ^ sdata;
  assign last_bit_d = (cnt_q == CNT_W'(KEY_WIDTH - 1));
  assign xfer_d     = svalid && (state_q != IDLE);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else if (zeroize) begin
      // Beats start and any transfer on the same edge.
      state_q     <= IDLE;
      shadow_q    <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= LOAD;
            shadow_q  <= '0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            key_err_q <= 1'b0;
          end
        end

        LOAD: begin
          if (start) begin
            // Restart; a transfer on this edge is dropped.
            state_q  <= LOAD;
            shadow_q <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
          end else if (xfer_d) begin
            shadow_q <= shadow_d;
            par_q    <= par_d;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_bit_d) begin
              state_q <= PARITY;
            end
          end
        end

        PARITY: begin
          if (start) begin
            state_q  <= LOAD;
            shadow_q <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
          end else if (xfer_d) begin
            state_q <= IDLE;
            if (par_d == 1'b0) begin
              key_q       <= shadow_q;
              key_valid_q <= 1'b1;
              key_err_q   <= 1'b0;
            end else begin
              key_q       <= '0;
              key_valid_q <= 1'b0;
              key_err_q   <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from registers or from the registered state.
  assign sready    = (state_q != IDLE);
  assign busy      = sready;
  assign keyinput  = key_q;
  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;

endmodule

// File: doc/key_loader.md
# key_loader

Serial key-delivery block for logic-locked netlists. It receives a key bit-serially over a valid/ready stream from tamper-proof storage or a test harness, and checks an even-parity trailer bit. On a good check it commits the key in one step onto the parallel `keyinput` bus that drives the key gates of a locked core. Until a valid key is committed, and after any error or zeroize, the bus holds all-zeros, which leaves the core in its locked, corrupted behaviour.

## Interface
Reset is asynchronous and active-high; one clock.

Parameters:
- `KEY_WIDTH`, default 2: number of key bits; legal range 1–256.

Ports:
- `CK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous active-high reset.
- `start`  in  1  begin (or restart) a key load.
- `zeroize`  in  1  synchronous clear of the key and all status.
- `sdata`  in  1  serial key or parity bit.
- `svalid`  in  1  `sdata` is valid this cycle.
- `sready`  out  1  the block accepts `sdata` this cycle.
- `keyinput`  out  KEY_WIDTH  committed key to the locked core.
- `key_valid`  out  1  `keyinput` holds a parity-checked key.
- `key_err`  out  1  the last load failed its parity check.
- `busy`  out  1  a load is in progress.

## Operation
- States:
  - IDLE: waiting for `start`.
  - LOAD: receiving key bits.
  - PARITY: receiving the trailer bit.
- Internal storage:
  - `shadow`, KEY_WIDTH bits.
  - Bit counter, width clog2(KEY_WIDTH+1).
  - Running parity, 1 bit.
- A transfer occurs on a rising edge where `svalid` and `sready` are both 1.
- IDLE:
  - `start`=1 moves to LOAD.
  - The same edge clears `shadow`, the counter, the running parity and `key_err`.
- LOAD:
  - The k-th transfer (k from 0) writes `sdata` to `shadow[k]`, so delivery is LSB-first.
  - Each transfer XORs `sdata` into the running parity.
  - The transfer with k = KEY_WIDTH−1 moves to PARITY.
- PARITY:
  - One transfer completes the load. The check passes when running parity XOR `sdata` = 0 (even parity).
  - Pass, on the same edge: `keyinput` ← `shadow`, `key_valid` ← 1, `key_err` ← 0, state → IDLE.
  - Fail, on the same edge: `keyinput` ← 0, `key_valid` ← 0, `key_err` ← 1, state → IDLE.
- During LOAD and PARITY, `keyinput` and `key_valid` keep their previous values. A prior good key stays applied until the new load commits or fails.
- `start` in LOAD or PARITY:
  - Restarts the load: `shadow`, counter and parity are cleared and the state returns to LOAD.
  - Any transfer on that edge is discarded.
- `zeroize`=1, in any state:
  - Same edge: `keyinput` ← 0, `key_valid` ← 0, `key_err` ← 0, `shadow` ← 0, state → IDLE.
  - Overrides `start` and any transfer on that edge.
- `start` in IDLE while `key_valid`=1 is legal (re-keying).
- `svalid` while `sready`=0 is ignored; no data is lost or stored.
- `sdata` is a don't-care when `svalid`=0.

## Timing
- Reset values:
  - `keyinput`=0, `key_valid`=0, `key_err`=0, `busy`=0, `sready`=0.
  - State IDLE; `shadow`, counter and parity all 0.
- Outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
  - `sready` = 1 exactly in LOAD or PARITY.
  - `busy` = `sready`.
- `start` sampled at edge t gives `sready`=1 from cycle t+1.
- With `svalid` held high, a load takes KEY_WIDTH+1 cycles after `start`. The commit is visible on `keyinput` and `key_valid` in the cycle after the edge that accepts the parity bit.
- Gaps in `svalid` stall the counter indefinitely; there is no timeout.
- `RST` asserted mid-load aborts immediately and asynchronously to reset values. The load does not resume after `RST` deasserts.

## Test plan
All scenarios use KEY_WIDTH=2.
- Good load: `start`, then transfers 1, 0, parity 1 back-to-back.
  - Required: `keyinput`=2'b01 and `key_valid`=1 three cycles after `sready` rises.
  - Required: `busy`=0 the same cycle.
- Bad parity: bits 1, 1, parity 1.
  - Required: `keyinput`=0, `key_valid`=0, `key_err`=1.
  - Then a good load (0, 1, 1): `keyinput`=2'b10 and `key_err`=0.
- Backpressure and gaps: `svalid` toggled 1,0,0,1,0,1 carrying 0, 1, parity 1.
  - Required: exactly three transfers, giving `keyinput`=2'b10.
  - Required: `svalid` asserted before `start` has no effect.
- Re-key and restart:
  - With key 2'b01 committed, `start`, send bit 1, assert `start` again, then send 1, 1, 0.
  - Required: `keyinput` stays 2'b01 until the final transfer, then becomes 2'b11 with `key_valid`=1.
- Zeroize priority: with key 2'b11 valid, start a load and, after one bit, assert `zeroize` and `start` together.
  - Required: the next cycle shows `keyinput`=0, `key_valid`=0, `busy`=0, state IDLE.
- Async reset mid-load: pulse `RST` between two CK edges after one bit.
  - Required: outputs reach reset values before the next edge.
  - Required: a subsequent full good load commits correctly.
